if_unit: RTL and testbench
==========================

// Module: if_unit
// PURPOSE
//  Instruction fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
//  Owns the PC and drives a synchronous-read instruction memory (1-cycle read latency).
//  Presents each fetched instruction, its PC+1 and the pre-sliced fields to decode.
//  Holds on data_hazard stalls, and flushes on control-flow redirects (branch/call/ret resolved in EX).
// PARAMETERS
//  PC_RESET  32'h0000_0000  word address fetched first after reset
//  NOP_INSTR 32'h0000_0000  instruction word driven when ifid_valid=0
// PORTS
//  clk           in   1   clock, all state on posedge
//  rst           in   1   reset, synchronous, active-low
//  data_hazard   in   1   stall: hold PC and IF/ID contents
//  redirect      in   1   taken branch/call/ret: flush and restart at redirect_pc
//  redirect_pc   in   32  word address of the new fetch target
//  imem_addr     out  32  instruction memory word address
//  imem_rd_en    out  1   instruction memory read enable
//  imem_rdata    in   32  instruction word for the address presented on the previous cycle
//  ifid_valid    out  1   IF/ID holds a real instruction
//  ifid_instr    out  32  instruction word (NOP_INSTR when invalid)
//  PC_out        out  32  PC+1 of the instruction in IF/ID
//  R_I_A_type_rd out  5   ifid_instr[25:21]
//  R_type_rt     out  5   ifid_instr[20:16]
//  R_I_type_rs   out  5   ifid_instr[15:11]
//  R_type_shamt  out  5   ifid_instr[10:6]
//  I_type_imm    out  16  ifid_instr[15:0]
//  J_type_imm    out  26  ifid_instr[25:0]
//  A_type_imm    out  21  ifid_instr[20:0]
//  halted        out  1   fetch stopped on HALT (0 when feature compiled out)
// BEHAVIOUR
//  State: fetch_pc (next address to issue), issued_pc/issued_valid (address in flight), IF/ID regs.
//  Reset (rst=0 at edge): fetch_pc=PC_RESET; issued_valid=0; ifid_valid=0; ifid_instr=NOP_INSTR;
//    PC_out=0; halted=0. imem_rd_en=0 while rst=0.
//  imem_addr is combinational: issued_pc when data_hazard=1 && redirect=0, else fetch_pc.
//  Normal cycle: issued_pc<=fetch_pc; issued_valid<=1; fetch_pc<=fetch_pc+1.
//    IF/ID <= {issued_valid, imem_rdata, issued_pc+1}.
//  Stall (data_hazard=1, redirect=0): fetch_pc, issued_*, and IF/ID all hold.
//    issued_pc is re-presented, so imem_rdata still matches IF/ID's pending word after release.
//  Redirect (priority over stall): fetch_pc<=redirect_pc; issued_valid<=0; ifid_valid<=0.
//    Redirect at cycle t: bubbles in IF/ID after edges t and t+1; target valid after edge t+2.
//  ifid_valid=0 forces ifid_instr=NOP_INSTR and all field outputs to 0; PC_out holds its last value.
//  Arithmetic: all PC math is 32-bit modulo. 32'hFFFF_FFFF wraps to 0; PC_out = pc+1 mod 2^32.
//  First valid IF/ID appears 2 edges after rst rises.
//  Reset mid-stall or mid-redirect: reset wins and all state is reinitialised.
// CONFIGURATION
//  Macro IF_UNIT_HALT_EN:
//    defined: when a valid word with opcode [31:26]==OPC_HALT loads into IF/ID, halted<=1 at that edge.
//      While halted: fetch_pc frozen, issued_valid<=0, imem_rd_en=0, following IF/ID loads are bubbles.
//      The HALT word itself stays visible in IF/ID for decode until the next edge.
//      Only reset clears halted; redirect is ignored while halted.
//    undefined: halted tied 0; OPC_HALT is fetched like any other word.
// STRUCTURE
//  cpu_pkg: NOP_INSTR, OPC_HALT=6'h3F, field bit-position localparams (shared with decode).
//  Sub-module ifid_reg: IF/ID register with hold (stall) and clear (flush) controls, plus field slicing.
//  if_unit keeps the PC/issue logic and the halt flag.
// TESTING
//  Reset release, imem returns addr as data -> IF/ID valid after 2 edges: instr=0, PC_out=1; then 1, 2...
//  Stall 3 cycles while IF/ID holds PC_out=5 -> held 3 cycles; after release sequence 6, 7 has no skip/duplicate.
//  Redirect to 0x40 while IF/ID holds PC_out=8 -> 2 bubbles (ifid_valid=0, instr=0), then PC_out=0x41.
//  redirect=1 and data_hazard=1 same cycle -> redirect taken, same 2-bubble timing as redirect alone.
//  PC_RESET=32'hFFFF_FFFF -> first instr from 0xFFFFFFFF with PC_out=0; next fetch address 0.
//  IF_UNIT_HALT_EN, HALT word at addr 3 -> halted=1 after it enters IF/ID; imem_rd_en=0, bubbles until rst.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared constants, field positions and IF/ID payload type.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [5:0]  OPC_HALT  = 6'h3F;

    // Field bit positions, shared with decode.
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int RD_MSB    = 25;
    localparam int RD_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RS_MSB    = 15;
    localparam int RS_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int IIMM_MSB  = 15;
    localparam int JIMM_MSB  = 25;
    localparam int AIMM_MSB  = 20;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc_plus1;
    } ifid_t;

    function automatic logic [5:0] opcode(input logic [31:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_unit_ifid.sv
`default_nettype none
// ============================================================================
//  Module   : ifid_reg
//  Purpose  : IF/ID pipeline register with hold/clear and decode field slicing.
//  Revision : 1.0  initial release
// ============================================================================
module ifid_reg #(
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_hold,
    input  logic        i_clear,
    input  logic        i_load_valid,
    input  logic [31:0] i_load_instr,
    input  logic [31:0] i_load_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_shamt,
    output logic [15:0] o_i_imm,
    output logic [25:0] o_j_imm,
    output logic [20:0] o_a_imm
);
    import cpu_pkg::*;

    ifid_t ifid_q;
    ifid_t ifid_d;

    // The PC field only moves on a real instruction so decode keeps the last PC+1 across bubbles.
    always_comb begin
        ifid_d = ifid_q;
        if (i_clear) begin
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
        end else if (!i_hold) begin
            ifid_d.valid = i_load_valid;
            ifid_d.instr = i_load_valid ? i_load_instr : NOP_INSTR;
            if (i_load_valid) begin
                ifid_d.pc_plus1 = i_load_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ifid_q.valid    <= 1'b0;
            ifid_q.instr    <= NOP_INSTR;
            ifid_q.pc_plus1 <= 32'h0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    always_comb begin
        o_valid = ifid_q.valid;
        o_instr = ifid_q.valid ? ifid_q.instr : NOP_INSTR;
        o_pc    = ifid_q.pc_plus1;
        o_rd    = '0;
        o_rt    = '0;
        o_rs    = '0;
        o_shamt = '0;
        o_i_imm = '0;
        o_j_imm = '0;
        o_a_imm = '0;
        if (ifid_q.valid) begin
            o_rd    = ifid_q.instr[RD_MSB:RD_LSB];
            o_rt    = ifid_q.instr[RT_MSB:RT_LSB];
            o_rs    = ifid_q.instr[RS_MSB:RS_LSB];
            o_shamt = ifid_q.instr[SHAMT_MSB:SHAMT_LSB];
            o_i_imm = ifid_q.instr[IIMM_MSB:0];
            o_j_imm = ifid_q.instr[JIMM_MSB:0];
            o_a_imm = ifid_q.instr[AIMM_MSB:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_unit.sv
`default_nettype none
// ============================================================================
//  Module   : if_unit
//  Purpose  : Instruction fetch (PC, imem issue, stall/redirect) feeding IF/ID.
//             Optional HALT support is enabled by defining IF_UNIT_HALT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module if_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_hazard,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_rd_en,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] PC_out,
    output logic [4:0]  R_I_A_type_rd,
    output logic [4:0]  R_type_rt,
    output logic [4:0]  R_I_type_rs,
    output logic [4:0]  R_type_shamt,
    output logic [15:0] I_type_imm,
    output logic [25:0] J_type_imm,
    output logic [20:0] A_type_imm,
    output logic        halted
);
    import cpu_pkg::*;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] issued_pc_q, issued_pc_d;
    logic        issued_valid_q, issued_valid_d;
    logic        halted_q, halted_d;
    logic        w_ifid_hold;
    logic        w_ifid_clear;
    logic        w_halt_seen;

`ifdef IF_UNIT_HALT_EN
    assign w_halt_seen = issued_valid_q && (opcode(imem_rdata) == OPC_HALT);
`else
    assign w_halt_seen = 1'b0;
`endif

    // Halt dominates redirect, redirect dominates stall.
    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        issued_pc_d    = issued_pc_q;
        issued_valid_d = issued_valid_q;
        halted_d       = halted_q;
        w_ifid_hold    = 1'b0;
        w_ifid_clear   = 1'b0;
        if (halted_q) begin
            issued_valid_d = 1'b0;
            w_ifid_clear   = 1'b1;
        end else if (redirect) begin
            fetch_pc_d     = redirect_pc;
            issued_valid_d = 1'b0;
            w_ifid_clear   = 1'b1;
        end else if (data_hazard) begin
            w_ifid_hold    = 1'b1;
        end else begin
            issued_pc_d    = fetch_pc_q;
            issued_valid_d = 1'b1;
            fetch_pc_d     = fetch_pc_q + 32'd1;
            halted_d       = w_halt_seen;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q     <= PC_RESET;
            issued_pc_q    <= PC_RESET;
            issued_valid_q <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            issued_pc_q    <= issued_pc_d;
            issued_valid_q <= issued_valid_d;
            halted_q       <= halted_d;
        end
    end

    // Re-presenting the in-flight address during a stall keeps imem_rdata aligned on release.
    assign imem_addr  = (data_hazard && !redirect) ? issued_pc_q : fetch_pc_q;
    assign imem_rd_en = rst && !halted_q;
    assign halted     = halted_q;

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk          (clk),
        .rst          (rst),
        .i_hold       (w_ifid_hold),
        .i_clear      (w_ifid_clear),
        .i_load_valid (issued_valid_q),
        .i_load_instr (imem_rdata),
        .i_load_pc    (issued_pc_q + 32'd1),
        .o_valid      (ifid_valid),
        .o_instr      (ifid_instr),
        .o_pc         (PC_out),
        .o_rd         (R_I_A_type_rd),
        .o_rt         (R_type_rt),
        .o_rs         (R_I_type_rs),
        .o_shamt      (R_type_shamt),
        .o_i_imm      (I_type_imm),
        .o_j_imm      (J_type_imm),
        .o_a_imm      (A_type_imm)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_unit
//  Purpose  : Directed scoreboard bench for if_unit (default and wrap-reset PC).
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_unit;

    typedef struct packed {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        halted;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_hazard;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt_word_en = 1'b0;

    logic [31:0] addr0, addr1;
    logic        rd_en0, rd_en1;
    logic [31:0] rdata0 = 32'h0;
    logic [31:0] rdata1 = 32'h0;
    logic        valid0, valid1, halted0, halted1;
    logic [31:0] instr0, instr1, pc0, pc1;
    logic [4:0]  rd0, rt0, rs0, sh0, rd1, rt1, rs1, sh1;
    logic [15:0] ii0, ii1;
    logic [25:0] ji0, ji1;
    logic [20:0] ai0, ai1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    if_unit u_dut0 (
        .clk (clk), .rst (rst), .data_hazard (data_hazard), .redirect (redirect),
        .redirect_pc (redirect_pc), .imem_addr (addr0), .imem_rd_en (rd_en0),
        .imem_rdata (rdata0), .ifid_valid (valid0), .ifid_instr (instr0), .PC_out (pc0),
        .R_I_A_type_rd (rd0), .R_type_rt (rt0), .R_I_type_rs (rs0), .R_type_shamt (sh0),
        .I_type_imm (ii0), .J_type_imm (ji0), .A_type_imm (ai0), .halted (halted0)
    );

    if_unit #(.PC_RESET (32'hFFFF_FFFF)) u_dut1 (
        .clk (clk), .rst (rst), .data_hazard (data_hazard), .redirect (redirect),
        .redirect_pc (redirect_pc), .imem_addr (addr1), .imem_rd_en (rd_en1),
        .imem_rdata (rdata1), .ifid_valid (valid1), .ifid_instr (instr1), .PC_out (pc1),
        .R_I_A_type_rd (rd1), .R_type_rt (rt1), .R_I_type_rs (rs1), .R_type_shamt (sh1),
        .I_type_imm (ii1), .J_type_imm (ji1), .A_type_imm (ai1), .halted (halted1)
    );

    // Memory returns its own address, except an optional HALT word at address 3.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (halt_word_en && a == 32'd3) ? 32'hFC00_0003 : a;
    endfunction

    always @(posedge clk) begin
        if (rd_en0) rdata0 <= mem_word(addr0);
        if (rd_en1) rdata1 <= mem_word(addr1);
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t E(input logic v, input logic [31:0] i, input logic [31:0] p,
                               input logic h);
        exp_t e;
        e.v = v; e.instr = i; e.pc = p; e.halted = h;
        return e;
    endfunction

    always @(posedge clk) begin : monitor
        exp_t e;
        logic [82:0] fe;
        #1;
        if (q0.size() != 0) begin
            e  = q0.pop_front();
            fe = e.v ? {e.instr[25:21], e.instr[20:16], e.instr[15:11], e.instr[10:6],
                        e.instr[15:0], e.instr[25:0], e.instr[20:0]} : 83'h0;
            check("dut0_ifid", {valid0, instr0, pc0, halted0}, {e.v, e.instr, e.pc, e.halted});
            check("dut0_fields", {rd0, rt0, rs0, sh0, ii0, ji0, ai0}, fe);
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            check("dut1_ifid", {valid1, instr1, pc1, halted1}, {e.v, e.instr, e.pc, e.halted});
        end
    end

    task automatic step(input logic r, input logic dh, input logic rd, input logic [31:0] rpc,
                        input exp_t e0, input bit has1 = 1'b0, input exp_t e1 = '0);
        @(negedge clk);
        rst = r; data_hazard = dh; redirect = rd; redirect_pc = rpc;
        q0.push_back(e0);
        if (has1) q1.push_back(e1);
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; data_hazard = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

        // Reset and release; dut1 exercises the all-ones reset PC wrap.
        step(0, 0, 0, 0, E(0, 0, 0, 0), 1, E(0, 0, 0, 0));
        step(0, 0, 0, 0, E(0, 0, 0, 0), 1, E(0, 0, 0, 0));
        @(negedge clk);
        check("rd_en_in_reset", rd_en0, 0);
        step(1, 0, 0, 0, E(0, 0, 0, 0), 1, E(0, 0, 0, 0));
        #2 check("dut1_wrap_addr", addr1, 32'h0);
        step(1, 0, 0, 0, E(1, 0, 1, 0), 1, E(1, 32'hFFFF_FFFF, 0, 0));
        step(1, 0, 0, 0, E(1, 1, 2, 0), 1, E(1, 0, 1, 0));
        step(1, 0, 0, 0, E(1, 2, 3, 0), 1, E(1, 1, 2, 0));
        step(1, 0, 0, 0, E(1, 3, 4, 0));
        step(1, 0, 0, 0, E(1, 4, 5, 0));

        // Three-cycle stall holding PC_out=5, then no skip or duplicate.
        step(1, 1, 0, 0, E(1, 4, 5, 0));
        #2 check("stall_addr", addr0, 32'd5);
        step(1, 1, 0, 0, E(1, 4, 5, 0));
        step(1, 1, 0, 0, E(1, 4, 5, 0));
        step(1, 0, 0, 0, E(1, 5, 6, 0));
        step(1, 0, 0, 0, E(1, 6, 7, 0));
        step(1, 0, 0, 0, E(1, 7, 8, 0));

        // Redirect to 0x40: two bubbles, PC_out held, then the target.
        step(1, 0, 1, 32'h40, E(0, 0, 8, 0));
        step(1, 0, 0, 0,      E(0, 0, 8, 0));
        step(1, 0, 0, 0,      E(1, 32'h40, 32'h41, 0));
        step(1, 0, 0, 0,      E(1, 32'h41, 32'h42, 0));

        // Redirect with simultaneous stall behaves like redirect alone.
        step(1, 1, 1, 32'hA5A5_5A5A, E(0, 0, 32'h42, 0));
        step(1, 0, 0, 0, E(0, 0, 32'h42, 0));
        step(1, 0, 0, 0, E(1, 32'hA5A5_5A5A, 32'hA5A5_5A5B, 0));
        step(1, 0, 0, 0, E(1, 32'hA5A5_5A5B, 32'hA5A5_5A5C, 0));

        // Reset asserted mid-stall and mid-redirect.
        step(0, 1, 0, 0,      E(0, 0, 0, 0));
        step(1, 0, 0, 0,      E(0, 0, 0, 0));
        step(1, 0, 0, 0,      E(1, 0, 1, 0));
        step(0, 0, 1, 32'h99, E(0, 0, 0, 0));
        step(1, 0, 0, 0,      E(0, 0, 0, 0));
        step(1, 0, 0, 0,      E(1, 0, 1, 0));

`ifdef IF_UNIT_HALT_EN
        // HALT word at address 3: visible one cycle, then bubbles until reset.
        step(0, 0, 0, 0, E(0, 0, 0, 0));
        halt_word_en = 1'b1;
        step(1, 0, 0, 0, E(0, 0, 0, 0));
        step(1, 0, 0, 0, E(1, 0, 1, 0));
        step(1, 0, 0, 0, E(1, 1, 2, 0));
        step(1, 0, 0, 0, E(1, 2, 3, 0));
        step(1, 0, 0, 0, E(1, 32'hFC00_0003, 4, 1));
        step(1, 0, 0, 0, E(0, 0, 4, 1));
        #2 check("halt_rd_en", rd_en0, 0);
        step(1, 0, 1, 32'h10, E(0, 0, 4, 1));
        #2 check("halt_addr_frozen", addr0, 32'd5);
        step(1, 0, 0, 0, E(0, 0, 4, 1));
        step(0, 0, 0, 0, E(0, 0, 0, 0));
        halt_word_en = 1'b0;
`endif

        @(negedge clk);
        check("queue_drained", q0.size() + q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
